ad7864_seq: RTL and testbench
=============================

AD7864_SEQ -- requirements
Module: ad7864_seq

Interface
REQ-001 Parameter N_CHIPS, default 2, number of AD7864 devices sharing one data bus (1..4).
REQ-002 Parameter N_CH, default 4, channels converted per device per frame (1..4).
REQ-003 Parameter DATA_W, default 12, ADC data bus width.
REQ-004 Parameter CONV_LOW_CYC, default 4, ad_conv_bar low width in clkin cycles (>=1).
REQ-005 Parameter RD_LOW_CYC, default 3, ad_rd_bar low width in cycles (>=2); RD_GAP_CYC, default 2, rd high gap (>=1).
REQ-006 Parameter BUSY_TO_CYC, default 1023, busy timeout in cycles.
REQ-007 clkin  in  1  single system clock, all logic rising-edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 dsp_conv_bar  in  1  asynchronous DSP frame trigger, falling edge starts a frame.
REQ-010 ad_busy  in  1  asynchronous OR of device BUSY outputs.
REQ-011 ad_db  in  DATA_W  shared ADC data bus.
REQ-012 ad_conv_bar  out  1  CONVST to all devices, active low.
REQ-013 ad_cs_bar  out  N_CHIPS  per-device chip select, one-hot low.
REQ-014 ad_rd_bar  out  1  shared read strobe, active low.
REQ-015 smp_data/smp_chip/smp_ch/smp_valid  out  DATA_W/2/2/1  captured word, source indices, one-cycle strobe.
REQ-016 db_rdy  out  1  one-cycle pulse after last word of a frame.
REQ-017 overrun, timeout  out  1 each  sticky error flags, cleared by next accepted trigger.

Function
REQ-018 dsp_conv_bar and ad_busy SHALL pass a 2-flop synchroniser; trigger = synchronised falling edge.
REQ-019 States: IDLE, CONV, WAIT_HI, WAIT_LO, RD_LOW, RD_GAP, DONE.
REQ-020 IDLE: on trigger, clear error flags, go CONV, drive ad_conv_bar low the next cycle.
REQ-021 CONV: hold ad_conv_bar low exactly CONV_LOW_CYC cycles, then high, go WAIT_HI.
REQ-022 WAIT_HI: wait synchronised busy high; WAIT_LO: wait busy low, then go RD_LOW with chip=0, ch=0.
REQ-023 A single counter SHALL run across WAIT_HI+WAIT_LO; reaching BUSY_TO_CYC sets timeout, releases all strobes, returns IDLE, no db_rdy.
REQ-024 RD_LOW: ad_cs_bar[chip] and ad_rd_bar low RD_LOW_CYC cycles; ad_db sampled on last low cycle; smp_valid pulses next cycle with smp_chip/smp_ch.
REQ-025 RD_GAP: rd_bar high RD_GAP_CYC cycles; cs_bar stays low while ch<N_CH-1, high between devices.
REQ-026 Order: ch increments 0..N_CH-1, then chip increments; after chip N_CHIPS-1, ch N_CH-1 go DONE.
REQ-027 DONE: pulse db_rdy one cycle, return IDLE; frame yields exactly N_CHIPS*N_CH smp_valid pulses.
REQ-028 Trigger in any non-IDLE state SHALL set overrun and be ignored; frame continues.
REQ-029 ad_rd_bar and ad_conv_bar SHALL never be low simultaneously; at most one ad_cs_bar bit low.
REQ-030 All outputs registered; no combinational path input to output.

Reset
REQ-031 rst_n low: state IDLE, ad_conv_bar=1, ad_rd_bar=1, ad_cs_bar all 1, smp_* 0, db_rdy=0, overrun=0, timeout=0, counters 0, synchronisers 1 (conv) / 0 (busy).
REQ-032 Reset mid-frame SHALL release all strobes immediately; no smp_valid/db_rdy until a new trigger after deassertion.

Structure
REQ-033 Package ad7864_pkg SHALL hold the state enumeration and index-width constants.
REQ-034 Sub-module ad7864_sync (2-flop synchroniser, async reset, parametrised reset value) instantiated twice.

Verification
REQ-035 N_CHIPS=2,N_CH=4: trigger, busy high 5 cycles then low -> 8 smp_valid in order (0,0)..(1,3), data matches bus model, db_rdy once.
REQ-036 Trigger -> ad_conv_bar low exactly 4 cycles; rd_bar low 3 / high 2 cycles per word.
REQ-037 Busy never asserts, BUSY_TO_CYC=63 -> timeout=1 after 63 cycles, no smp_valid, no db_rdy, IDLE.
REQ-038 Second trigger during read phase -> overrun=1, frame still 8 words, cleared on next trigger.
REQ-039 rst_n low during word 3 -> all strobes high within reset, outputs zero, next trigger yields clean frame.
REQ-040 N_CHIPS=1,N_CH=1 -> single word, cs_bar[0] low only during read, db_rdy one cycle after smp_valid.

Source files
------------

// File: rtl/ad7864_pkg.sv
// Shared types and constants for the AD7864 conversion/readout sequencer.
package ad7864_pkg;

    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitHi,
        StWaitLo,
        StRdLow,
        StRdGap,
        StDone
    } state_e;

endpackage

// File: rtl/ad7864_seq_if.sv
// ADC bus, DSP trigger and sample-output signals of the AD7864 sequencer.
interface ad7864_seq_if #(
    parameter int unsigned N_CHIPS = 2,
    parameter int unsigned DATA_W  = 12
);
    import ad7864_pkg::*;

    logic                dsp_conv_bar;
    logic                ad_busy;
    logic [DATA_W-1:0]   ad_db;
    logic                ad_conv_bar;
    logic [N_CHIPS-1:0]  ad_cs_bar;
    logic                ad_rd_bar;
    logic [DATA_W-1:0]   smp_data;
    logic [IDX_W-1:0]    smp_chip;
    logic [IDX_W-1:0]    smp_ch;
    logic                smp_valid;
    logic                db_rdy;
    logic                overrun;
    logic                timeout;

    modport master (
        input  dsp_conv_bar, ad_busy, ad_db,
        output ad_conv_bar, ad_cs_bar, ad_rd_bar,
        output smp_data, smp_chip, smp_ch, smp_valid, db_rdy, overrun, timeout
    );

    modport slave (
        output dsp_conv_bar, ad_busy, ad_db,
        input  ad_conv_bar, ad_cs_bar, ad_rd_bar,
        input  smp_data, smp_chip, smp_ch, smp_valid, db_rdy, overrun, timeout
    );
endinterface

// File: rtl/ad7864_sync.sv
// Two-flop synchroniser with a selectable reset value.
module ad7864_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ad7864_seq.sv
// Frame sequencer: CONVST pulse, BUSY handshake, then chip/channel ordered readout.
module ad7864_seq
    import ad7864_pkg::*;
#(
    parameter int unsigned N_CHIPS      = 2,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned CONV_LOW_CYC = 4,
    parameter int unsigned RD_LOW_CYC   = 3,
    parameter int unsigned RD_GAP_CYC   = 2,
    parameter int unsigned BUSY_TO_CYC  = 1023
) (
    input  logic         clkin,
    input  logic         rst_n,
    ad7864_seq_if.master bus
);
    localparam int unsigned CNT_W =
        $clog2(BUSY_TO_CYC + CONV_LOW_CYC + RD_LOW_CYC + RD_GAP_CYC + 1);

    logic             conv_s, busy_s, conv_prev, trig;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] chip, ch;
    logic             last_ch, last_chip;

    ad7864_sync #(.RST_VAL(1'b1)) u_sync_conv (
        .clkin(clkin), .rst_n(rst_n), .d(bus.dsp_conv_bar), .q(conv_s)
    );
    ad7864_sync #(.RST_VAL(1'b0)) u_sync_busy (
        .clkin(clkin), .rst_n(rst_n), .d(bus.ad_busy), .q(busy_s)
    );

    assign trig      = conv_prev & ~conv_s;
    assign last_ch   = (ch == IDX_W'(N_CH - 1));
    assign last_chip = (chip == IDX_W'(N_CHIPS - 1));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state           <= StIdle;
            conv_prev       <= 1'b1;
            cnt             <= '0;
            chip            <= '0;
            ch              <= '0;
            bus.ad_conv_bar <= 1'b1;
            bus.ad_rd_bar   <= 1'b1;
            bus.ad_cs_bar   <= '1;
            bus.smp_data    <= '0;
            bus.smp_chip    <= '0;
            bus.smp_ch      <= '0;
            bus.smp_valid   <= 1'b0;
            bus.db_rdy      <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.timeout     <= 1'b0;
        end else begin
            conv_prev     <= conv_s;
            bus.smp_valid <= 1'b0;
            bus.db_rdy    <= 1'b0;
            if (trig && state != StIdle) bus.overrun <= 1'b1;

            case (state)
                StIdle: if (trig) begin
                    bus.overrun     <= 1'b0;
                    bus.timeout     <= 1'b0;
                    bus.ad_conv_bar <= 1'b0;
                    cnt             <= '0;
                    state           <= StConv;
                end
                StConv: if (cnt == CNT_W'(CONV_LOW_CYC - 1)) begin
                    bus.ad_conv_bar <= 1'b1;
                    cnt             <= '0;
                    state           <= StWaitHi;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // One counter spans both busy phases so the timeout bounds the whole handshake.
                StWaitHi, StWaitLo: if (cnt == CNT_W'(BUSY_TO_CYC - 1)) begin
                    bus.timeout     <= 1'b1;
                    bus.ad_conv_bar <= 1'b1;
                    bus.ad_rd_bar   <= 1'b1;
                    bus.ad_cs_bar   <= '1;
                    cnt             <= '0;
                    state           <= StIdle;
                end else if (state == StWaitHi) begin
                    cnt <= cnt + 1'b1;
                    if (busy_s) state <= StWaitLo;
                end else if (!busy_s) begin
                    chip          <= '0;
                    ch            <= '0;
                    bus.ad_cs_bar <= ~N_CHIPS'(1);
                    bus.ad_rd_bar <= 1'b0;
                    cnt           <= '0;
                    state         <= StRdLow;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                StRdLow: if (cnt == CNT_W'(RD_LOW_CYC - 1)) begin
                    bus.smp_data  <= DATA_W'(bus.ad_db);
                    bus.smp_chip  <= chip;
                    bus.smp_ch    <= ch;
                    bus.smp_valid <= 1'b1;
                    bus.ad_rd_bar <= 1'b1;
                    cnt           <= '0;
                    if (last_ch) bus.ad_cs_bar <= '1;
                    state <= (last_ch && last_chip) ? StDone : StRdGap;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                StRdGap: if (cnt == CNT_W'(RD_GAP_CYC - 1)) begin
                    cnt           <= '0;
                    bus.ad_rd_bar <= 1'b0;
                    state         <= StRdLow;
                    if (last_ch) begin
                        ch            <= '0;
                        chip          <= chip + 1'b1;
                        bus.ad_cs_bar <= ~(N_CHIPS'(1) << (chip + 1'b1));
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                StDone: begin
                    bus.db_rdy <= 1'b1;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_ad7864_seq.sv
// Scoreboard bench: a 2x4 sequencer with short busy timeout and a 1x1 sequencer.
module tb_ad7864_seq;
    typedef struct packed {
        logic [11:0] data;
        logic [1:0]  chip;
        logic [1:0]  ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int cyc = 0, inv_err = 0;
    int word_idx = 0;
    int db_cnt0 = 0, db_cnt1 = 0;
    int valid_cyc1 = 0, db_cyc1 = 0, cs1_low = 0;
    int conv_run = 0, rd_lo = 0, rd_hi = 0, words_in_frame = 0;
    exp_t q0[$];
    exp_t q1[$];

    ad7864_seq_if #(.N_CHIPS(2), .DATA_W(12)) bus0 ();
    ad7864_seq_if #(.N_CHIPS(1), .DATA_W(12)) bus1 ();

    ad7864_seq #(
        .N_CHIPS(2), .N_CH(4), .DATA_W(12), .CONV_LOW_CYC(4),
        .RD_LOW_CYC(3), .RD_GAP_CYC(2), .BUSY_TO_CYC(63)
    ) dut0 (.clkin(clk), .rst_n(rst_n), .bus(bus0.master));

    ad7864_seq #(
        .N_CHIPS(1), .N_CH(1), .DATA_W(12), .CONV_LOW_CYC(4),
        .RD_LOW_CYC(3), .RD_GAP_CYC(2), .BUSY_TO_CYC(63)
    ) dut1 (.clkin(clk), .rst_n(rst_n), .bus(bus1.master));

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(posedge clk) cyc++;

    // ADC bus model: each read strobe presents {chip+1, word index} on the bus.
    always @(negedge bus0.ad_rd_bar) begin
        #1;
        bus0.ad_db = {(bus0.ad_cs_bar == 2'b10) ? 4'h1 :
                      (bus0.ad_cs_bar == 2'b01) ? 4'h2 : 4'hF, 8'(word_idx)};
        word_idx++;
    end

    always @(negedge clk) begin
        if (rst_n && bus0.smp_valid) begin
            if (q0.size() == 0) check("dut0 unexpected smp_valid", 1, 0);
            else begin
                exp_t e;
                e = q0.pop_front();
                check("dut0 smp_data", bus0.smp_data, e.data);
                check("dut0 smp_chip", bus0.smp_chip, e.chip);
                check("dut0 smp_ch", bus0.smp_ch, e.ch);
            end
        end
        if (bus0.db_rdy) db_cnt0++;
    end

    always @(negedge clk) begin
        if (rst_n && bus1.smp_valid) begin
            valid_cyc1 = cyc;
            if (q1.size() == 0) check("dut1 unexpected smp_valid", 1, 0);
            else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 smp_data", bus1.smp_data, e.data);
                check("dut1 smp_chip", bus1.smp_chip, e.chip);
                check("dut1 smp_ch", bus1.smp_ch, e.ch);
            end
        end
        if (bus1.db_rdy) begin db_cnt1++; db_cyc1 = cyc; end
        if (!bus1.ad_cs_bar[0]) cs1_low++;
    end

    // Strobe widths on dut0.
    always @(negedge clk) begin
        if (!rst_n) begin
            conv_run = 0; rd_lo = 0; rd_hi = 0; words_in_frame = 0;
        end else begin
            if (!bus0.ad_conv_bar) begin
                if (conv_run == 0) words_in_frame = 0;
                conv_run++;
            end else if (conv_run > 0) begin
                check("conv_bar low width", conv_run, 4);
                conv_run = 0;
            end
            if (!bus0.ad_rd_bar) begin
                if (rd_lo == 0 && words_in_frame > 0) check("rd_bar gap width", rd_hi, 2);
                rd_lo++;
                rd_hi = 0;
            end else begin
                if (rd_lo > 0) begin
                    check("rd_bar low width", rd_lo, 3);
                    rd_lo = 0;
                    words_in_frame++;
                end
                rd_hi++;
            end
        end
    end

    always @(negedge clk) begin
        if (!bus0.ad_rd_bar && !bus0.ad_conv_bar) inv_err++;
        if ($countones(~bus0.ad_cs_bar) > 1) inv_err++;
        if (!bus1.ad_rd_bar && !bus1.ad_conv_bar) inv_err++;
        if (bus1.ad_cs_bar[0] != bus1.ad_rd_bar) inv_err++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic logic conv_of(input int sel);
        return (sel == 0) ? bus0.ad_conv_bar : bus1.ad_conv_bar;
    endfunction

    task automatic trigger(input int sel);
        @(posedge clk); #1;
        if (sel == 0) bus0.dsp_conv_bar = 1'b0; else bus1.dsp_conv_bar = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if (sel == 0) bus0.dsp_conv_bar = 1'b1; else bus1.dsp_conv_bar = 1'b1;
    endtask

    task automatic wait_conv_done(input int sel, output bit ok);
        int n;
        n = 0;
        while (conv_of(sel) != 1'b0 && n < 60) begin @(negedge clk); n++; end
        while (conv_of(sel) != 1'b1 && n < 60) begin @(negedge clk); n++; end
        ok = (n < 60);
        if (!ok) check("conv_bar pulse seen", 0, 1);
    endtask

    task automatic busy_pulse(input int sel);
        bit ok;
        wait_conv_done(sel, ok);
        if (ok) begin
            @(negedge clk);
            if (sel == 0) bus0.ad_busy = 1'b1; else bus1.ad_busy = 1'b1;
            repeat (5) @(negedge clk);
            if (sel == 0) bus0.ad_busy = 1'b0; else bus1.ad_busy = 1'b0;
        end
    endtask

    task automatic wait_db(input int sel, input int start);
        int n;
        n = 0;
        while (((sel == 0) ? db_cnt0 : db_cnt1) == start && n < 300) begin
            @(negedge clk); n++;
        end
        if (n >= 300) check("db_rdy arrived", 0, 1);
    endtask

    task automatic push_frame0();
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.data = {4'(k / 4 + 1), 8'(k)};
            e.chip = 2'(k / 4);
            e.ch   = 2'(k % 4);
            q0.push_back(e);
        end
    endtask

    task automatic run_frame0();
        int db0;
        push_frame0();
        word_idx = 0;
        db0 = db_cnt0;
        trigger(0);
        busy_pulse(0);
        check("overrun cleared by trigger", bus0.overrun, 0);
        check("timeout cleared by trigger", bus0.timeout, 0);
        wait_db(0, db0);
        repeat (3) @(negedge clk);
        check("db_rdy pulses per frame", db_cnt0 - db0, 1);
        check("words left after frame", q0.size(), 0);
    endtask

    initial begin
        int db0, n;
        bus0.dsp_conv_bar = 1'b1; bus0.ad_busy = 1'b0; bus0.ad_db = '0;
        bus1.dsp_conv_bar = 1'b1; bus1.ad_busy = 1'b0; bus1.ad_db = 12'h5A3;
        repeat (3) @(negedge clk);
        check("reset conv_bar", bus0.ad_conv_bar, 1);
        check("reset rd_bar", bus0.ad_rd_bar, 1);
        check("reset cs_bar", bus0.ad_cs_bar, 2'b11);
        check("reset smp_valid", bus0.smp_valid, 0);
        check("reset smp_data", bus0.smp_data, 0);
        check("reset db_rdy", bus0.db_rdy, 0);
        check("reset overrun", bus0.overrun, 0);
        check("reset timeout", bus0.timeout, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_frame0();

        fork
            run_frame0();
            begin : inject
                int m;
                m = 0;
                while (word_idx < 3 && m < 400) begin @(negedge clk); m++; end
                trigger(0);
            end
        join
        check("overrun sticky after retrigger", bus0.overrun, 1);
        run_frame0();

        // Busy never rises: expect timeout 63 cycles after CONVST ends.
        begin
            bit ok;
            db0 = db_cnt0;
            trigger(0);
            wait_conv_done(0, ok);
            n = 0;
            while (!bus0.timeout && n < 200) begin @(negedge clk); n++; end
            check("timeout latency", n, 63);
            repeat (5) @(negedge clk);
            check("timeout sticky", bus0.timeout, 1);
            check("no db_rdy on timeout", db_cnt0 - db0, 0);
            check("cs_bar released on timeout", bus0.ad_cs_bar, 2'b11);
            check("rd_bar released on timeout", bus0.ad_rd_bar, 1);
        end
        run_frame0();

        // Reset while word 3 is being read.
        push_frame0();
        word_idx = 0;
        db0 = db_cnt0;
        trigger(0);
        busy_pulse(0);
        n = 0;
        while (word_idx < 4 && n < 300) begin @(negedge clk); n++; end
        check("reached word 3", word_idx, 4);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("mid reset rd_bar", bus0.ad_rd_bar, 1);
        check("mid reset cs_bar", bus0.ad_cs_bar, 2'b11);
        check("mid reset conv_bar", bus0.ad_conv_bar, 1);
        check("mid reset smp_valid", bus0.smp_valid, 0);
        check("mid reset smp_data", bus0.smp_data, 0);
        check("words outstanding at reset", q0.size(), 5);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no db_rdy after reset", db_cnt0 - db0, 0);
        run_frame0();

        // Single chip, single channel.
        begin
            exp_t e;
            int db1;
            e.data = 12'h5A3; e.chip = 2'd0; e.ch = 2'd0;
            q1.push_back(e);
            cs1_low = 0;
            db1 = db_cnt1;
            trigger(1);
            busy_pulse(1);
            wait_db(1, db1);
            repeat (3) @(negedge clk);
            check("dut1 db_rdy count", db_cnt1 - db1, 1);
            check("dut1 words left", q1.size(), 0);
            check("dut1 db_rdy after smp_valid", db_cyc1 - valid_cyc1, 1);
            check("dut1 cs_bar low cycles", cs1_low, 3);
        end

        check("strobe invariants", inv_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
